// File: rtl/ysyx_22040750_lsu_xbar_pkg.sv
// Shared definitions for the LSU data-side crossbar: CLINT region defaults,
// slave-select encoding and the read/write FSM state encodings.
package ysyx_22040750_lsu_xbar_pkg;

  localparam logic [31:0] CLINT_BASE_DFLT = 32'h0200_0000;
  localparam logic [31:0] CLINT_SIZE_DFLT = 32'h0001_0000;

  typedef enum logic {
    SEL_MEM   = 1'b0,
    SEL_CLINT = 1'b1
  } sel_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_DATA  = 2'd1,
    W_BWAIT = 2'd2,
    W_BRESP = 2'd3
  } wstate_e;

endpackage

// File: rtl/ysyx_22040750_addr_dec.sv
// Combinational address decoder: CLINT when the address falls inside the
// size-aligned CLINT window, MEM otherwise.
module ysyx_22040750_addr_dec
  import ysyx_22040750_lsu_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DFLT,
  parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DFLT
) (
  input  logic [31:0] addr,
  output sel_e        sel
);

  // Size is a power of two and the base is aligned, so a masked compare suffices.
  localparam logic [31:0] REGION_MASK = ~(CLINT_SIZE - 32'd1);

  always_comb begin
    sel = ((addr & REGION_MASK) == CLINT_BASE) ? SEL_CLINT : SEL_MEM;
  end

endmodule

// File: rtl/ysyx_22040750_lsu_xbar.sv
// 1-master / 2-slave AXI-lite-style crossbar between the LSU and CLINT/MEM.
// Independent read and write FSMs, one outstanding transaction each.
module ysyx_22040750_lsu_xbar
  import ysyx_22040750_lsu_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DFLT,
  parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DFLT
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [31:0] I_m_araddr,
  input  logic        I_m_arvalid,
  output logic        O_m_arready,
  output logic [63:0] O_m_rdata,
  output logic        O_m_rvalid,
  input  logic        I_m_rready,
  input  logic [31:0] I_m_awaddr,
  input  logic        I_m_awvalid,
  output logic        O_m_awready,
  input  logic [63:0] I_m_wdata,
  input  logic [7:0]  I_m_wstrb,
  input  logic        I_m_wvalid,
  output logic        O_m_wready,
  output logic        O_m_bvalid,
  input  logic        I_m_bready,
  output logic [31:0] O_clint_araddr,
  output logic        O_clint_arvalid,
  input  logic        I_clint_arready,
  input  logic [63:0] I_clint_rdata,
  input  logic        I_clint_rvalid,
  output logic        O_clint_rready,
  output logic [31:0] O_clint_awaddr,
  output logic        O_clint_awvalid,
  input  logic        I_clint_awready,
  output logic [63:0] O_clint_wdata,
  output logic [7:0]  O_clint_wstrb,
  output logic        O_clint_wvalid,
  input  logic        I_clint_wready,
  input  logic        I_clint_bvalid,
  output logic        O_clint_bready,
  output logic [31:0] O_mem_araddr,
  output logic        O_mem_arvalid,
  input  logic        I_mem_arready,
  input  logic [63:0] I_mem_rdata,
  input  logic        I_mem_rvalid,
  output logic        O_mem_rready,
  output logic [31:0] O_mem_awaddr,
  output logic        O_mem_awvalid,
  input  logic        I_mem_awready,
  output logic [63:0] O_mem_wdata,
  output logic [7:0]  O_mem_wstrb,
  output logic        O_mem_wvalid,
  input  logic        I_mem_wready,
  input  logic        I_mem_bvalid,
  output logic        O_mem_bready
);

  sel_e    ar_sel, aw_sel;
  sel_e    rsel, rsel_nxt, wsel, wsel_nxt;
  rstate_e rstate, rstate_nxt;
  wstate_e wstate, wstate_nxt;
  logic    sel_wready, sel_bvalid;

  ysyx_22040750_addr_dec #(.CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE)) u_ar_dec (
    .addr (I_m_araddr),
    .sel  (ar_sel)
  );

  ysyx_22040750_addr_dec #(.CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE)) u_aw_dec (
    .addr (I_m_awaddr),
    .sel  (aw_sel)
  );

  // Address and data lines fan out to both slaves; only valids/readies are steered.
  assign O_clint_araddr = I_m_araddr;
  assign O_mem_araddr   = I_m_araddr;
  assign O_clint_awaddr = I_m_awaddr;
  assign O_mem_awaddr   = I_m_awaddr;
  assign O_clint_wdata  = I_m_wdata;
  assign O_mem_wdata    = I_m_wdata;
  assign O_clint_wstrb  = I_m_wstrb;
  assign O_mem_wstrb    = I_m_wstrb;
  assign O_m_rdata      = (rsel == SEL_CLINT) ? I_clint_rdata : I_mem_rdata;
  assign O_m_bvalid     = (wstate == W_BRESP);
  assign sel_wready     = (wsel == SEL_CLINT) ? I_clint_wready : I_mem_wready;
  assign sel_bvalid     = (wsel == SEL_CLINT) ? I_clint_bvalid : I_mem_bvalid;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rstate <= R_IDLE;
      rsel   <= SEL_MEM;
      wstate <= W_IDLE;
      wsel   <= SEL_MEM;
    end else begin
      rstate <= rstate_nxt;
      rsel   <= rsel_nxt;
      wstate <= wstate_nxt;
      wsel   <= wsel_nxt;
    end
  end

  always_comb begin
    rstate_nxt      = rstate;
    rsel_nxt        = rsel;
    O_m_arready     = 1'b0;
    O_m_rvalid      = 1'b0;
    O_clint_arvalid = 1'b0;
    O_mem_arvalid   = 1'b0;
    O_clint_rready  = 1'b0;
    O_mem_rready    = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (ar_sel == SEL_CLINT) begin
          O_clint_arvalid = I_m_arvalid;
          O_m_arready     = I_clint_arready;
        end else begin
          O_mem_arvalid = I_m_arvalid;
          O_m_arready   = I_mem_arready;
        end
        if (I_m_arvalid && O_m_arready) begin
          rstate_nxt = R_WAIT;
          rsel_nxt   = ar_sel;
        end
      end
      R_WAIT: begin
        if (rsel == SEL_CLINT) begin
          O_m_rvalid     = I_clint_rvalid;
          O_clint_rready = I_m_rready;
        end else begin
          O_m_rvalid   = I_mem_rvalid;
          O_mem_rready = I_m_rready;
        end
        if (O_m_rvalid && I_m_rready) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_nxt      = wstate;
    wsel_nxt        = wsel;
    O_m_awready     = 1'b0;
    O_m_wready      = 1'b0;
    O_clint_awvalid = 1'b0;
    O_mem_awvalid   = 1'b0;
    O_clint_wvalid  = 1'b0;
    O_mem_wvalid    = 1'b0;
    O_clint_bready  = 1'b0;
    O_mem_bready    = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (aw_sel == SEL_CLINT) begin
          O_clint_awvalid = I_m_awvalid;
          O_m_awready     = I_clint_awready;
        end else begin
          O_mem_awvalid = I_m_awvalid;
          O_m_awready   = I_mem_awready;
        end
        if (I_m_awvalid && O_m_awready) begin
          wstate_nxt = W_DATA;
          wsel_nxt   = aw_sel;
        end
      end
      W_DATA: begin
        O_m_wready = sel_wready;
        if (wsel == SEL_CLINT) begin
          O_clint_wvalid = I_m_wvalid;
          O_clint_bready = 1'b1;
        end else begin
          O_mem_wvalid = I_m_wvalid;
          O_mem_bready = 1'b1;
        end
        // A slave may answer B in the same cycle it accepts W; capture it here.
        if (I_m_wvalid && sel_wready) wstate_nxt = sel_bvalid ? W_BRESP : W_BWAIT;
      end
      W_BWAIT: begin
        if (wsel == SEL_CLINT) O_clint_bready = 1'b1;
        else                   O_mem_bready   = 1'b1;
        if (sel_bvalid) wstate_nxt = W_BRESP;
      end
      W_BRESP: begin
        if (I_m_bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040750_lsu_xbar.sv
// Directed bench for the LSU crossbar: drives master and both slaves by hand
// and checks steering, response routing, B buffering and reset behaviour.
module tb_ysyx_22040750_lsu_xbar;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [31:0] I_m_araddr;
  logic        I_m_arvalid;
  logic        O_m_arready;
  logic [63:0] O_m_rdata;
  logic        O_m_rvalid;
  logic        I_m_rready;
  logic [31:0] I_m_awaddr;
  logic        I_m_awvalid;
  logic        O_m_awready;
  logic [63:0] I_m_wdata;
  logic [7:0]  I_m_wstrb;
  logic        I_m_wvalid;
  logic        O_m_wready;
  logic        O_m_bvalid;
  logic        I_m_bready;
  logic [31:0] O_clint_araddr;
  logic        O_clint_arvalid;
  logic        I_clint_arready;
  logic [63:0] I_clint_rdata;
  logic        I_clint_rvalid;
  logic        O_clint_rready;
  logic [31:0] O_clint_awaddr;
  logic        O_clint_awvalid;
  logic        I_clint_awready;
  logic [63:0] O_clint_wdata;
  logic [7:0]  O_clint_wstrb;
  logic        O_clint_wvalid;
  logic        I_clint_wready;
  logic        I_clint_bvalid;
  logic        O_clint_bready;
  logic [31:0] O_mem_araddr;
  logic        O_mem_arvalid;
  logic        I_mem_arready;
  logic [63:0] I_mem_rdata;
  logic        I_mem_rvalid;
  logic        O_mem_rready;
  logic [31:0] O_mem_awaddr;
  logic        O_mem_awvalid;
  logic        I_mem_awready;
  logic [63:0] O_mem_wdata;
  logic [7:0]  O_mem_wstrb;
  logic        O_mem_wvalid;
  logic        I_mem_wready;
  logic        I_mem_bvalid;
  logic        O_mem_bready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 I_clk = ~I_clk;

  ysyx_22040750_lsu_xbar dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_m_araddr(I_m_araddr), .I_m_arvalid(I_m_arvalid), .O_m_arready(O_m_arready),
    .O_m_rdata(O_m_rdata), .O_m_rvalid(O_m_rvalid), .I_m_rready(I_m_rready),
    .I_m_awaddr(I_m_awaddr), .I_m_awvalid(I_m_awvalid), .O_m_awready(O_m_awready),
    .I_m_wdata(I_m_wdata), .I_m_wstrb(I_m_wstrb), .I_m_wvalid(I_m_wvalid), .O_m_wready(O_m_wready),
    .O_m_bvalid(O_m_bvalid), .I_m_bready(I_m_bready),
    .O_clint_araddr(O_clint_araddr), .O_clint_arvalid(O_clint_arvalid), .I_clint_arready(I_clint_arready),
    .I_clint_rdata(I_clint_rdata), .I_clint_rvalid(I_clint_rvalid), .O_clint_rready(O_clint_rready),
    .O_clint_awaddr(O_clint_awaddr), .O_clint_awvalid(O_clint_awvalid), .I_clint_awready(I_clint_awready),
    .O_clint_wdata(O_clint_wdata), .O_clint_wstrb(O_clint_wstrb), .O_clint_wvalid(O_clint_wvalid),
    .I_clint_wready(I_clint_wready), .I_clint_bvalid(I_clint_bvalid), .O_clint_bready(O_clint_bready),
    .O_mem_araddr(O_mem_araddr), .O_mem_arvalid(O_mem_arvalid), .I_mem_arready(I_mem_arready),
    .I_mem_rdata(I_mem_rdata), .I_mem_rvalid(I_mem_rvalid), .O_mem_rready(O_mem_rready),
    .O_mem_awaddr(O_mem_awaddr), .O_mem_awvalid(O_mem_awvalid), .I_mem_awready(I_mem_awready),
    .O_mem_wdata(O_mem_wdata), .O_mem_wstrb(O_mem_wstrb), .O_mem_wvalid(O_mem_wvalid),
    .I_mem_wready(I_mem_wready), .I_mem_bvalid(I_mem_bvalid), .O_mem_bready(O_mem_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  // AR decode probe without a handshake (all arready low while valid is up).
  task automatic probe_ar(input logic [31:0] addr, input logic exp_clint);
    step();
    I_m_araddr = addr;
    I_m_arvalid = 1'b1;
    #1;
    chk("dec_clint_arvalid", O_clint_arvalid, exp_clint);
    chk("dec_mem_arvalid", O_mem_arvalid, !exp_clint);
    I_m_arvalid = 1'b0;
  endtask

  initial begin
    I_rst = 1'b1;
    I_m_araddr = '0; I_m_arvalid = 0; I_m_rready = 0;
    I_m_awaddr = '0; I_m_awvalid = 0; I_m_wdata = '0; I_m_wstrb = '0; I_m_wvalid = 0; I_m_bready = 0;
    I_clint_arready = 0; I_clint_rdata = '0; I_clint_rvalid = 0;
    I_clint_awready = 0; I_clint_wready = 0; I_clint_bvalid = 0;
    I_mem_arready = 0; I_mem_rdata = '0; I_mem_rvalid = 0;
    I_mem_awready = 0; I_mem_wready = 0; I_mem_bvalid = 0;
    step();
    step();
    I_rst = 1'b0;
    #1;
    chk("rst_m_arready", O_m_arready, 0);
    chk("rst_m_rvalid", O_m_rvalid, 0);
    chk("rst_m_awready", O_m_awready, 0);
    chk("rst_m_wready", O_m_wready, 0);
    chk("rst_m_bvalid", O_m_bvalid, 0);

    // CLINT read
    step();
    I_m_araddr = 32'h0200_BFF8; I_m_arvalid = 1; I_clint_arready = 1; I_mem_arready = 1;
    #1;
    chk("rd_clint_arvalid", O_clint_arvalid, 1);
    chk("rd_mem_arvalid", O_mem_arvalid, 0);
    chk("rd_m_arready", O_m_arready, 1);
    chk("rd_clint_araddr", O_clint_araddr, 64'h0200_BFF8);
    step();
    I_m_arvalid = 0; I_clint_rvalid = 1; I_clint_rdata = 64'h1234; I_m_rready = 1;
    #1;
    chk("rd_m_rvalid", O_m_rvalid, 1);
    chk("rd_m_rdata", O_m_rdata, 64'h1234);
    chk("rd_clint_rready", O_clint_rready, 1);
    chk("rd_wait_arready", O_m_arready, 0);
    chk("rd_wait_mem_arvalid", O_mem_arvalid, 0);
    step();
    I_clint_rvalid = 0; I_m_rready = 0; I_clint_arready = 0; I_mem_arready = 0;
    #1;
    chk("rd_done_rvalid", O_m_rvalid, 0);

    // Decode boundaries
    probe_ar(32'h0200_FFFF, 1'b1);
    probe_ar(32'h0201_0000, 1'b0);
    probe_ar(32'h01FF_FFFF, 1'b0);

    // CLINT write, AW+W together, single-cycle slave bvalid, B backpressure
    step();
    I_m_awaddr = 32'h0200_4000; I_m_awvalid = 1; I_m_wdata = 64'h100; I_m_wstrb = 8'hFF; I_m_wvalid = 1;
    I_clint_awready = 1; I_clint_wready = 1;
    #1;
    chk("wr_clint_awvalid", O_clint_awvalid, 1);
    chk("wr_mem_awvalid", O_mem_awvalid, 0);
    chk("wr_m_awready", O_m_awready, 1);
    chk("wr_idle_wready", O_m_wready, 0);
    chk("wr_idle_clint_wvalid", O_clint_wvalid, 0);
    step();
    I_m_awvalid = 0; I_clint_awready = 0;
    #1;
    chk("wr_data_wready", O_m_wready, 1);
    chk("wr_data_clint_wvalid", O_clint_wvalid, 1);
    chk("wr_data_clint_bready", O_clint_bready, 1);
    chk("wr_data_clint_wdata", O_clint_wdata, 64'h100);
    chk("wr_data_clint_wstrb", O_clint_wstrb, 8'hFF);
    step();
    I_m_wvalid = 0; I_clint_wready = 0; I_clint_bvalid = 1;
    #1;
    chk("wr_bwait_bvalid", O_m_bvalid, 0);
    chk("wr_bwait_bready", O_clint_bready, 1);
    chk("wr_bwait_mem_bready", O_mem_bready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      I_clint_bvalid = 0; I_m_bready = 0;
      #1;
      chk("wr_bresp_held", O_m_bvalid, 1);
    end
    step();
    I_m_bready = 1;
    #1;
    chk("wr_bresp_hs", O_m_bvalid, 1);
    step();
    I_m_bready = 0;
    #1;
    chk("wr_bresp_drop", O_m_bvalid, 0);

    // Concurrency: MEM read outstanding while a CLINT write completes
    step();
    I_m_araddr = 32'h8000_0000; I_m_arvalid = 1; I_mem_arready = 1;
    #1;
    chk("cc_mem_arvalid", O_mem_arvalid, 1);
    chk("cc_clint_arvalid", O_clint_arvalid, 0);
    step();
    I_m_arvalid = 0; I_mem_arready = 0; I_m_rready = 1;
    I_m_awaddr = 32'h0200_0000; I_m_awvalid = 1; I_clint_awready = 1;
    #1;
    chk("cc_m_awready", O_m_awready, 1);
    chk("cc_clint_awvalid", O_clint_awvalid, 1);
    chk("cc_rvalid_0", O_m_rvalid, 0);
    step();
    I_m_awvalid = 0; I_clint_awready = 0;
    I_m_wdata = 64'h55; I_m_wvalid = 1; I_clint_wready = 1; I_clint_bvalid = 1;
    #1;
    chk("cc_m_wready", O_m_wready, 1);
    chk("cc_mem_rready", O_mem_rready, 1);
    chk("cc_clint_rready", O_clint_rready, 0);
    step();
    I_m_wvalid = 0; I_clint_wready = 0; I_clint_bvalid = 0; I_m_bready = 1;
    #1;
    chk("cc_bvalid", O_m_bvalid, 1);
    chk("cc_rvalid_1", O_m_rvalid, 0);
    step();
    I_m_bready = 0;
    #1;
    chk("cc_bvalid_drop", O_m_bvalid, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("cc_rvalid_stall", O_m_rvalid, 0);
    end
    step();
    I_mem_rvalid = 1; I_mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    I_clint_rdata = 64'h1111;
    #1;
    chk("cc_rvalid", O_m_rvalid, 1);
    chk("cc_rdata", O_m_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    // Back-to-back AR right after the R handshake
    step();
    I_mem_rvalid = 0; I_m_araddr = 32'h0200_0008; I_m_arvalid = 1; I_clint_arready = 1;
    #1;
    chk("b2b_arready", O_m_arready, 1);
    step();
    I_m_arvalid = 0; I_clint_arready = 0; I_clint_rvalid = 1; I_clint_rdata = 64'hABCD;
    #1;
    chk("b2b_rdata", O_m_rdata, 64'hABCD);
    chk("b2b_rvalid", O_m_rvalid, 1);
    step();
    I_clint_rvalid = 0; I_m_rready = 0;

    // Ordering: W before AW stalls
    I_m_wvalid = 1; I_m_wdata = 64'h77; I_clint_wready = 1; I_mem_wready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ord_wready_early", O_m_wready, 0);
      chk("ord_mem_wvalid_early", O_mem_wvalid, 0);
      step();
    end
    I_m_awaddr = 32'h8000_1000; I_m_awvalid = 1; I_mem_awready = 1;
    #1;
    chk("ord_awready", O_m_awready, 1);
    chk("ord_wready_aw", O_m_wready, 0);
    step();
    I_m_awvalid = 0; I_mem_awready = 0; I_clint_wready = 0;
    #1;
    chk("ord_wready", O_m_wready, 1);
    chk("ord_mem_wvalid", O_mem_wvalid, 1);
    chk("ord_clint_wvalid", O_clint_wvalid, 0);
    step();
    I_m_wvalid = 0; I_mem_wready = 0;
    #1;
    chk("ord_bwait_bready", O_mem_bready, 1);
    chk("ord_bwait_bvalid", O_m_bvalid, 0);

    // Reset while in W_BWAIT
    I_rst = 1;
    step();
    I_rst = 0; I_mem_bvalid = 1;
    I_m_awaddr = 32'h8000_2000; I_m_awvalid = 1; I_mem_awready = 1;
    #1;
    chk("rstw_bvalid", O_m_bvalid, 0);
    chk("rstw_mem_bready", O_mem_bready, 0);
    chk("rstw_awready", O_m_awready, 1);
    step();
    I_m_awvalid = 0; I_mem_awready = 0; I_mem_bvalid = 0;
    I_m_wvalid = 1; I_mem_wready = 1;
    #1;
    chk("rstw_wready", O_m_wready, 1);
    chk("rstw_bvalid_data", O_m_bvalid, 0);
    step();
    I_m_wvalid = 0; I_mem_wready = 0; I_mem_bvalid = 1;
    #1;
    chk("rstw_bvalid_bwait", O_m_bvalid, 0);
    step();
    I_mem_bvalid = 0; I_m_bready = 1;
    #1;
    chk("rstw_bvalid_resp", O_m_bvalid, 1);
    step();
    I_m_bready = 0;
    #1;
    chk("rstw_bvalid_done", O_m_bvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
